// File: rtl/gray_decoder.sv
// gray_decoder: registered 3-bit Gray-to-binary decoder with sequence tracking, wrap and error counters
module gray_decoder (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic [2:0] Gray,
  output logic [2:0] Binary,
  output logic       Locked,
  output logic       Overflow,
  output logic       Error,
  output logic [3:0] WrapCount,
  output logic [3:0] ErrCount
);
  typedef enum logic [1:0] {IDLE, LOCKED, ERROR, RESYNC} state_t;
  state_t     state;
  logic [2:0] ref_gray;
  logic [2:0] dec;
  logic       step;
  logic       hold;
  logic       wrap;
  always_comb begin
    dec  = {Gray[2], ^Gray[2:1], ^Gray};
    step = dec == Binary + 3'd1;
    hold = Gray == ref_gray;
    wrap = step && Binary == 3'd7;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      ref_gray  <= 3'd0;
      Binary    <= 3'd0;
      Locked    <= 1'b0;
      Overflow  <= 1'b0;
      Error     <= 1'b0;
      WrapCount <= 4'd0;
      ErrCount  <= 4'd0;
    end else begin
      Overflow <= 1'b0;
      if (En) begin
        case (state)
          IDLE: begin
            ref_gray <= Gray;
            Binary   <= dec;
            Locked   <= 1'b1;
            state    <= LOCKED;
          end
          ERROR: begin
            ref_gray <= Gray;
            Binary   <= dec;
            state    <= RESYNC;
          end
          default: begin
            // LOCKED and RESYNC share rules: a legal step (re)locks, a hold waits, anything else errors
            if (step) begin
              ref_gray  <= Gray;
              Binary    <= dec;
              Overflow  <= wrap;
              WrapCount <= WrapCount + {3'd0, wrap && WrapCount != 4'hf};
              Locked    <= 1'b1;
              Error     <= 1'b0;
              state     <= LOCKED;
            end else if (!hold) begin
              ErrCount <= ErrCount + {3'd0, ErrCount != 4'hf};
              Locked   <= 1'b0;
              Error    <= 1'b1;
              state    <= ERROR;
            end
          end
        endcase
      end
    end
  end
endmodule
